// File: rtl/cap_pkt_sched.sv
// cap_pkt_sched - capture packet scheduler.
// Reads a completed capture buffer and streams it to the ADC pads as framed
// packets: one leading idle interval, then fixed-length packets with gaps.
// Build option: define CAP_SELF_TEST_EN to include the internal counting
// pattern generator selected by self_test_mode.
module cap_pkt_sched #(
  parameter int DATA_W    = 18,
  parameter int ADDR_W    = 16,
  parameter int CAP_WORDS = 1728
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rstn,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic [7:0]        cfg_gap,
  input  logic [1:0]        cfg_data_length,
  input  logic [7:0]        cfg_idle_length,
  input  logic              self_test_mode,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              pkt_sof,
  output logic              pkt_eof,
  output logic              busy,
  output logic              done
);

  localparam int PKT_W = 11;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic              again_q, again_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PKT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        idle_q, idle_d;
  logic [1:0]        len_q, len_d;
  logic              vld_q, vld_d;
  logic              sof_q, sof_d;
  logic              eof_q, eof_d;
  logic              start_edge, again_edge, trigger;
  logic              rd_fire, rd_sof, rd_eof;
  logic [PKT_W-1:0]  pkt_last;

  // Edge detector copies follow the regfile levels, even during soft reset
  always_comb begin
    start_d    = capture_start;
    again_d    = capture_again;
    start_edge = capture_start & ~start_q;
    again_edge = capture_again & ~again_q;
    trigger    = ((state_q == S_IDLE) & start_edge) |
                 ((state_q == S_DONE) & ~vld_q & (start_edge | again_edge));
    pkt_last   = (PKT_W'(216) << len_q) - PKT_W'(1);
  end

  // Run sequencing: latch config, idle lead-in, packets, gaps, completion
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    word_cnt_d = word_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_d      = gap_q;
    idle_d     = idle_q;
    len_d      = len_q;
    rd_fire    = 1'b0;
    rd_sof     = 1'b0;
    rd_eof     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (trigger) begin
          gap_d      = cfg_gap;
          idle_d     = cfg_idle_length;
          len_d      = cfg_data_length;
          rd_addr_d  = '0;
          word_cnt_d = '0;
          wait_cnt_d = '0;
          state_d    = (cfg_idle_length == 8'd0) ? S_DATA : S_PRE;
        end
      end
      S_PRE: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_q == idle_q - 8'd1) begin
          wait_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        rd_fire    = 1'b1;
        rd_sof     = (word_cnt_q == '0);
        rd_addr_d  = rd_addr_q + ADDR_W'(1);
        word_cnt_d = word_cnt_q + PKT_W'(1);
        if (rd_addr_q == LAST_ADDR) begin
          rd_eof  = 1'b1;
          state_d = S_DONE;
        end else if (word_cnt_q == pkt_last) begin
          rd_eof     = 1'b1;
          word_cnt_d = '0;
          wait_cnt_d = '0;
          if (gap_q != 8'd0) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_q == gap_q - 8'd1) begin
          wait_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!sw_rstn) begin
      state_d    = S_IDLE;
      rd_addr_d  = '0;
      word_cnt_d = '0;
      wait_cnt_d = '0;
      gap_d      = '0;
      idle_d     = '0;
      len_d      = '0;
    end
  end

  // Output pipeline stage lines framing up with the SRAM read latency
  always_comb begin
    vld_d = rd_fire & sw_rstn;
    sof_d = rd_sof & sw_rstn;
    eof_d = rd_eof & sw_rstn;
  end

  // State, counter, latched config and pipeline registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      again_q    <= 1'b0;
      rd_addr_q  <= '0;
      word_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_q      <= '0;
      idle_q     <= '0;
      len_q      <= '0;
      vld_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      again_q    <= again_d;
      rd_addr_q  <= rd_addr_d;
      word_cnt_q <= word_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_q      <= gap_d;
      idle_q     <= idle_d;
      len_q      <= len_d;
      vld_q      <= vld_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
    end
  end

  assign mem_rd_addr    = rd_addr_q;
  assign adc_data_valid = vld_q;
  assign pkt_sof        = sof_q;
  assign pkt_eof        = eof_q;
  assign busy           = ((state_q != S_IDLE) && (state_q != S_DONE)) || vld_q;
  assign done           = (state_q == S_DONE) && !vld_q;

`ifdef CAP_SELF_TEST_EN
  logic              st_q, st_d;
  logic [DATA_W-1:0] tst_q, tst_d;
  logic [DATA_W-1:0] tst_data_q, tst_data_d;

  // Pattern counter restarts each run and advances once per streamed word
  always_comb begin
    st_d       = st_q;
    tst_d      = tst_q;
    tst_data_d = tst_data_q;
    if (trigger) begin
      st_d  = self_test_mode;
      tst_d = '0;
    end else if (rd_fire) begin
      tst_data_d = tst_q;
      tst_d      = tst_q + DATA_W'(1);
    end
    if (!sw_rstn) begin
      st_d       = 1'b0;
      tst_d      = '0;
      tst_data_d = '0;
    end
  end

  // Self-test mode and pattern registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q       <= 1'b0;
      tst_q      <= '0;
      tst_data_q <= '0;
    end else begin
      st_q       <= st_d;
      tst_q      <= tst_d;
      tst_data_q <= tst_data_d;
    end
  end

  assign mem_rd_en = rd_fire & ~st_q;
  assign adc_data  = vld_q ? (st_q ? tst_data_q : mem_rd_data) : '0;
`else
  logic unused_self_test;
  assign unused_self_test = self_test_mode;
  assign mem_rd_en        = rd_fire;
  assign adc_data         = vld_q ? mem_rd_data : '0;
`endif

endmodule

// File: doc/cap_pkt_sched.md
# cap_pkt_sched

Capture packet scheduler: after a capture-start request, it reads a completed ADC capture buffer and streams it to the output pads as framed packets. Each run has one leading idle interval, then fixed-length data packets separated by programmable gaps. It sits between the capture SRAM and the ADC_DATA/ADC_DATA_VALID pad drivers. It takes its configuration from the top regfile fields capture_start, capture_again, pktctrl_gap, pkt_data_length, pkt_idle_length, self_test_mode and pktctrl_sw_rstn.

## Interface
- DATA_W, 18, sample/pad data width
- ADDR_W, 16, capture buffer address width
- CAP_WORDS, 1728, total words streamed per run (1..2^ADDR_W)

- clk  in  1  packet-control clock (gated by pktctrl_clk_en upstream)
- rstn  in  1  asynchronous active-low reset
- sw_rstn  in  1  soft reset, active-low, sampled synchronously
- capture_start  in  1  level from regfile; rising edge starts a run
- capture_again  in  1  level; rising edge replays the buffer from DONE
- cfg_gap  in  8  idle cycles between packets
- cfg_data_length  in  2  packet length: 216 << cfg_data_length (216/432/864/1728)
- cfg_idle_length  in  8  idle cycles before the first packet
- self_test_mode  in  1  select the internal pattern instead of the SRAM
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  ADDR_W  SRAM read address
- mem_rd_data  in  DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en
- adc_data  out  DATA_W  output word; 0 whenever adc_data_valid=0
- adc_data_valid  out  1  output qualifier
- pkt_sof / pkt_eof  out  1 each  first/last word of a packet, aligned with adc_data_valid
- busy  out  1  run in progress, including the pipeline drain
- done  out  1  level; high from the cycle after the last word until the next run or a reset

## Operation
- Edge detectors: registers start_q and again_q, both reset to 0. A rising edge means input=1 and the registered copy=0.
- FSM states: IDLE, PRE, DATA, GAP, DONE. Reset state is IDLE.
- IDLE/DONE with a start edge, or DONE with an again edge:
  - Latch the cfg_* fields and self_test_mode.
  - Clear rd_addr, the packet word counter and the test counter.
  - Go to PRE.
  - Again edges in IDLE are ignored.
  - Start and again edges arriving together act as one start.
- Start and again edges while busy are ignored. Config changes during a run have no effect until the next run.
- PRE: count the latched idle_length cycles, then go to DATA. If idle_length=0, go straight to DATA.
- DATA: one read per cycle.
  - mem_rd_en=1, mem_rd_addr=rd_addr, then rd_addr++.
  - When the packet reaches its length and words remain, go to GAP; with gap=0 go directly back into DATA for the next packet.
  - When word CAP_WORDS-1 is read, go to DONE.
- Last packet truncation: if fewer words remain than the packet length, the last packet is shortened. pkt_eof marks word CAP_WORDS-1.
- GAP: count the latched gap cycles, then go to DATA.
- Output stage: a 1-cycle pipeline register.
  - adc_data_valid = registered mem_rd_en.
  - adc_data = mem_rd_data.
  - sof/eof are delayed together with the data.
- Reset values: every output is 0; mem_rd_addr=0.
- sw_rstn=0 at any clock edge:
  - FSM to IDLE, counters to 0, pipeline flushed, all outputs 0 on the next edge.
  - The run is not resumed when sw_rstn is released; a fresh start edge is required.
  - Edge registers keep sampling, so a start held high through the soft reset does not retrigger.
- rstn assertion clears all state asynchronously.

## Timing
- Start edge sampled at edge T:
  - State=PRE from T+1.
  - First mem_rd_en in cycle T+1+idle.
  - First adc_data_valid and pkt_sof in cycle T+2+idle.
- Between packets, adc_data_valid is low for exactly cfg_gap cycles.
- busy rises at T+1 and falls in the same cycle done rises, which is one cycle after the last valid word.
- Throughput: 1 word/cycle inside a packet.
- Total run length = 1 + idle + CAP_WORDS + gap×(packets−1) + 1 cycles.

## Configuration
- CAP_SELF_TEST_EN defined:
  - With the latched self_test_mode=1, mem_rd_en stays 0.
  - adc_data is an internal DATA_W-bit counter, starting at 0 each run and incremented per word, wrapping modulo 2^DATA_W.
  - Framing and timing are identical to SRAM mode.
- CAP_SELF_TEST_EN undefined: the pattern generator is absent, self_test_mode is ignored, and SRAM data is always used.

## Test plan
- CAP_WORDS=432, length=0, idle=15, gap=8:
  - Start edge at T -> first valid at T+17.
  - Two 216-word packets with addresses 0..215 and 216..431.
  - Valid low for exactly 8 cycles between them.
  - sof/eof on words 0/215/216/431; done at the cycle after the last word.
- CAP_WORDS=500, length=1 (432) -> packets of 432 and 68 words; eof on word 499; 500 mem reads total.
- gap=0, idle=0, CAP_WORDS=1728, length=0 -> first valid at T+2; valid continuous for 1728 cycles; sof/eof every 216 words.
- Timing of start and again edges:
  - Again edge in DONE -> identical replay from address 0.
  - Again edge during DATA -> ignored.
  - Start held high through DONE -> no retrigger.
- sw_rstn pulsed low mid-packet (word 100) -> next edge: all outputs 0, FSM IDLE, done=0. A new start edge replays from address 0.
- With CAP_SELF_TEST_EN, self_test_mode=1, CAP_WORDS=432, length=0 -> adc_data 0..431 with no mem_rd_en. Without the macro, the same stimulus -> SRAM data.
